load_store_unit: RTL

- Memory-stage load/store unit of the 5-stage RV32I pipeline.
- Takes the effective address, store data and access type from the EX/MEM register and runs a req/gnt/rvalid transaction on the data-memory bus.
- Formats load data by size, alignment and sign, and drives rdata into the MEM/WB register.
- Asserts StallM while an access is outstanding so the pipeline holds its registers.

---
 rtl/load_store_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one req/gnt/rvalid data-bus transaction per access,
// with load formatting and a response watchdog.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  funct3M,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        StallExt,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] rdata,
  output logic        StallM,
  output logic        lsu_exc
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;
  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  state_t      r_state, w_next;
  logic [7:0]  r_timer;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;
  logic        w_access, w_bad, w_go, w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_shift, w_ldata;

  assign w_access = MemReadM | MemWriteM;

  always_comb begin
    w_bad = 1'b0;
    if (MemReadM && MemWriteM)                                       w_bad = 1'b1;
    if (funct3M == 3'b011 || funct3M == 3'b110 || funct3M == 3'b111) w_bad = 1'b1;
    if (MemWriteM && funct3M[2])                                     w_bad = 1'b1;
    if (funct3M[1:0] == 2'b01 && ALUResultM[0])                      w_bad = 1'b1;
    if (funct3M[1:0] == 2'b10 && ALUResultM[1:0] != 2'b00)           w_bad = 1'b1;
  end

  assign w_go  = (r_state == S_IDLE) && w_access && !w_bad;
  assign w_tmo = (r_state == S_RESP) && !dmem_rvalid && (TIMEOUT_CYCLES != 0) && (r_timer == TMO);

  // Lane placement of store bytes; loads reuse the same enables.
  always_comb begin
    case (funct3M[1:0])
      2'b00:   begin w_be = 4'b0001 << ALUResultM[1:0]; w_wdata = {4{WriteDataM[7:0]}};  end
      2'b01:   begin w_be = 4'b0011 << ALUResultM[1:0]; w_wdata = {2{WriteDataM[15:0]}}; end
      default: begin w_be = 4'b1111;                    w_wdata = WriteDataM;            end
    endcase
  end

  assign w_shift = dmem_rdata >> {r_off, 3'b000};
  always_comb begin
    case (r_f3)
      3'b000:  w_ldata = {{24{w_shift[7]}},  w_shift[7:0]};
      3'b001:  w_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_ldata = {24'h0, w_shift[7:0]};
      3'b101:  w_ldata = {16'h0, w_shift[15:0]};
      default: w_ldata = w_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_go)                  w_next = S_REQ;
      S_REQ:  if (dmem_gnt)              w_next = S_RESP;
      S_RESP: if (dmem_rvalid || w_tmo)  w_next = S_DONE;
      S_DONE: if (!StallExt)             w_next = S_IDLE;
      default:                           w_next = S_IDLE;
    endcase
  end

  always_comb begin
    StallM  = w_access && !w_bad && (r_state != S_DONE);
    lsu_exc = ((r_state == S_IDLE) && w_access && w_bad) || w_tmo;
  end

  // Bus outputs are latched at issue so later EX/MEM changes cannot disturb them.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      rdata      <= '0;
      r_timer    <= '0;
      r_off      <= '0;
      r_f3       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_go) begin
          dmem_req   <= 1'b1;
          dmem_we    <= MemWriteM;
          dmem_addr  <= {ALUResultM[31:2], 2'b00};
          dmem_be    <= w_be;
          dmem_wdata <= w_wdata;
          r_off      <= ALUResultM[1:0];
          r_f3       <= funct3M;
        end
        S_REQ: if (dmem_gnt) begin
          dmem_req <= 1'b0;
          r_timer  <= '0;
        end
        S_RESP: begin
          if (dmem_rvalid) begin
            if (!dmem_we) rdata <= w_ldata;
          end else if (!w_tmo) begin
            r_timer <= r_timer + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
